// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared FSM state encoding and SPI mode-bit constants.
package spi_master_pkg;

    // Transfer phases: idle, select setup, data shifting, select hold.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    // Clock polarity: level of spi_clk while no edge is being generated.
    localparam logic CPOL_IDLE_LOW     = 1'b0;
    localparam logic CPOL_IDLE_HIGH    = 1'b1;

    // Clock phase: which spi_clk edge samples spi_di.
    localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
    localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: divides clk_sys into spi_clk half-periods and flags whether the
// edge that closes a shifting half-period is a leading or a trailing edge.
module spi_clkgen #(
    parameter int DIV_W = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             run,
    input  logic             shift_en,
    input  logic             active_level,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick,
    output logic             lead_edge,
    output logic             trail_edge
);

    logic [DIV_W-1:0] cnt_r;
    logic             tick_s;

    // A half-period ends on the clk_div-th cycle after it started.
    assign tick_s     = run && (cnt_r == clk_div);
    // spi_clk still at its idle level means the next toggle is the leading edge.
    assign tick       = tick_s;
    assign lead_edge  = tick_s & shift_en & ~active_level;
    assign trail_edge = tick_s & shift_en & active_level;

    // Count cycles within the current half-period; parked at zero while idle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (!run || tick_s) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: single-word SPI master with programmable mode, divider and
// chip select. Optional feature macro SPI_MASTER_LSB_FIRST_EN adds the
// lsb_first input; without it every transfer is MSB first.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  DIV_W  = 4,
    parameter int  CS_NUM = 2,
    localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              tx,
    input  logic              rx,
    input  logic [WIDTH-1:0]  din,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
    output logic [WIDTH-1:0]  dout,
    output logic              busy,
    output logic              done,
    output logic              spi_clk,
    output logic              spi_do,
    input  logic              spi_di,
    output logic [CS_NUM-1:0] cs_n
);

    localparam int                EDGE_W    = $clog2(2 * WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

    spi_state_t         state_r;
    logic [WIDTH-1:0]   tx_sr_r;
    logic [WIDTH-1:0]   rx_sr_r;
    logic [WIDTH-1:0]   dout_r;
    logic [EDGE_W-1:0]  edge_cnt_r;
    logic [DIV_W-1:0]   div_r;
    logic               cpol_r;
    logic               cpha_r;
    logic [CS_NUM-1:0]  cs_n_r;
    logic               spi_clk_r;
    logic               spi_do_r;
    logic               busy_r;
    logic               done_r;
    logic               lsb_s;
    logic               start_s;
    logic [WIDTH-1:0]   word_s;
    logic               tick_s;
    logic               lead_s;
    logic               trail_s;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic               lsb_r;
    assign lsb_s = lsb_r;
`else
    assign lsb_s = 1'b0;
`endif

    // tx has priority over rx; rx sends an all-ones word.
    assign start_s = tx | rx;
    assign word_s  = tx ? din : {WIDTH{1'b1}};

    // Bit that goes out next from the transmit shifter.
    function automatic logic tx_bit(input logic [WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[WIDTH-1];
    endfunction

    // Drop the bit just presented, back-filling with ones.
    function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] w, input logic lsb);
        return lsb ? {1'b1, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b1};
    endfunction

    // Insert a received bit so the word ends up in natural order.
    function automatic logic [WIDTH-1:0] rx_insert(input logic [WIDTH-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[WIDTH-1:1]} : {w[WIDTH-2:0], b};
    endfunction

    // One-cold select; out-of-range selects leave every line deasserted.
    function automatic logic [CS_NUM-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [CS_NUM-1:0] m;
        m = {CS_NUM{1'b1}};
        for (int i = 0; i < CS_NUM; i++) begin
            if (sel == CS_W'(i)) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .run          (state_r != IDLE),
        .shift_en     (state_r == SHIFT),
        .active_level (spi_clk_r ^ cpol_r),
        .clk_div      (div_r),
        .tick         (tick_s),
        .lead_edge    (lead_s),
        .trail_edge   (trail_s)
    );

    // Transfer sequencer: owns every registered output and the shift registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            tx_sr_r    <= {WIDTH{1'b1}};
            rx_sr_r    <= {WIDTH{1'b0}};
            dout_r     <= {WIDTH{1'b0}};
            edge_cnt_r <= {EDGE_W{1'b0}};
            div_r      <= {DIV_W{1'b0}};
            cpol_r     <= CPOL_IDLE_LOW;
            cpha_r     <= CPHA_SAMPLE_LEAD;
            cs_n_r     <= {CS_NUM{1'b1}};
            spi_clk_r  <= 1'b0;
            spi_do_r   <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_r      <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                        lsb_r      <= lsb_first;
`endif
                        div_r      <= clk_div;
                        cpol_r     <= cpol;
                        cpha_r     <= cpha;
                        spi_clk_r  <= cpol;
                        cs_n_r     <= cs_decode(cs_sel);
                        rx_sr_r    <= {WIDTH{1'b0}};
                        edge_cnt_r <= {EDGE_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= LEAD;
                        // Sample-on-leading mode must have the first bit valid
                        // before the first edge; the other mode presents it on that edge.
                        if (cpha == CPHA_SAMPLE_LEAD) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                            spi_do_r <= tx_bit(word_s, lsb_first);
                            tx_sr_r  <= tx_advance(word_s, lsb_first);
`else
                            spi_do_r <= tx_bit(word_s, 1'b0);
                            tx_sr_r  <= tx_advance(word_s, 1'b0);
`endif
                        end else begin
                            tx_sr_r  <= word_s;
                        end
                    end
                end
                LEAD: begin
                    if (tick_s) begin
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_s) begin
                        spi_clk_r  <= ~spi_clk_r;
                        edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
                        if ((lead_s && cpha_r == CPHA_SAMPLE_LEAD) ||
                            (trail_s && cpha_r == CPHA_SAMPLE_TRAIL)) begin
                            rx_sr_r  <= rx_insert(rx_sr_r, spi_di, lsb_s);
                        end else begin
                            spi_do_r <= tx_bit(tx_sr_r, lsb_s);
                            tx_sr_r  <= tx_advance(tx_sr_r, lsb_s);
                        end
                        if (edge_cnt_r == EDGE_LAST) begin
                            state_r <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (tick_s) begin
                        state_r  <= IDLE;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        cs_n_r   <= {CS_NUM{1'b1}};
                        dout_r   <= rx_sr_r;
                        spi_do_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dout    = dout_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign spi_clk = spi_clk_r;
    assign spi_do  = spi_do_r;
    assign cs_n    = cs_n_r;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 8, transfer word length in bits (4..32).
REQ-002 Parameter DIV_W, default 4, width of the clock-divider input.
REQ-003 Parameter CS_NUM, default 2, number of chip-select lines (1..8).
REQ-004 clk_sys  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 tx  input  1  start pulse; transmit din.
REQ-007 rx  input  1  start pulse; transmit all-ones and receive.
REQ-008 din  input  WIDTH  transmit word.
REQ-009 clk_div  input  DIV_W  half-period of spi_clk, in clk_sys cycles, minus 1.
REQ-010 cpol, cpha  input  1 each  SPI mode bits.
REQ-011 cs_sel  input  clog2(CS_NUM), minimum 1  target chip select.
REQ-012 dout  output  WIDTH  last received word.
REQ-013 busy  output  1  transfer in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 spi_clk, spi_do  output  1 each; spi_di  input  1; cs_n  output  CS_NUM  active-low selects.

Function
REQ-016 tx or rx SHALL be accepted only in IDLE; if both are high, tx SHALL win; starts while busy SHALL be ignored.
REQ-017 On acceptance, SHALL latch din (tx) or all-ones (rx), clk_div, cpol, cpha and cs_sel, then enter LEAD.
REQ-018 States: IDLE -> LEAD (one half-period, cs_n[cs_sel] low, spi_clk = cpol) -> SHIFT (2*WIDTH half-periods) -> TRAIL (one half-period) -> IDLE.
REQ-019 Half-period length SHALL be clk_div+1 clk_sys cycles; clk_div=0 toggles spi_clk every cycle.
REQ-020 cpha=0: the MSB SHALL be on spi_do from LEAD; spi_di sampled on leading edges; spi_do shifted on trailing edges.
REQ-021 cpha=1: spi_do shifted on leading edges (first edge presents MSB); spi_di sampled on trailing edges.
REQ-022 spi_clk SHALL rest at the latched cpol in IDLE, LEAD and TRAIL, and toggle exactly 2*WIDTH times per transfer.
REQ-023 Accept edge to done edge SHALL be exactly (2*WIDTH+2)*(clk_div+1) cycles; busy SHALL be high from the cycle after acceptance until done.
REQ-024 On the done edge: dout updates with the received word, busy falls, cs_n returns to all-ones.
REQ-025 A new start SHALL be accepted on the cycle done is high; it begins a new LEAD without an extra idle cycle.
REQ-026 dout SHALL hold its value between transfers; it SHALL NOT change during SHIFT.
REQ-027 A cs_sel value >= CS_NUM SHALL assert no chip select; the transfer still runs.

Reset
REQ-028 reset_n low SHALL immediately and at any point (including mid-transfer) force IDLE, busy=0, done=0, cs_n all ones, spi_clk=0, spi_do=1, dout=0, latched cpol=0.
REQ-029 An aborted transfer SHALL produce no done pulse and leave dout at 0.

Configuration
REQ-030 With SPI_MASTER_LSB_FIRST_EN defined, an input lsb_first (1 bit) SHALL exist and be latched at start; when 1, bits are sent and received LSB first.
REQ-031 Without SPI_MASTER_LSB_FIRST_EN, the port SHALL be absent and transfers SHALL be MSB first only.

Structure
REQ-032 Package spi_master_pkg SHALL hold the state enum (IDLE, LEAD, SHIFT, TRAIL) and the mode-bit constants.
REQ-033 Sub-module spi_clkgen SHALL produce the half-period tick and the leading/trailing edge strobes from clk_div.

Verification
REQ-034 WIDTH=8, clk_div=0, mode 0, tx din=0xA5, spi_di looped to spi_do -> dout=0xA5, done 18 cycles after acceptance, 8 rising spi_clk edges.
REQ-035 Mode 3, clk_div=3, rx, slave returns 0x3C -> spi_do all ones, dout=0x3C, done after 72 cycles, spi_clk idles high.
REQ-036 tx and rx asserted together with din=0x00 -> spi_do low throughout SHIFT; further tx while busy ignored (exactly one done).
REQ-037 reset_n pulsed low at the 5th spi_clk edge -> cs_n=all ones, busy=0 in the same cycle, no done, dout=0.
REQ-038 Back-to-back: tx held high on the done cycle with cs_sel 0 then 1 -> second LEAD immediately follows; cs_n goes 2'b10 then 2'b01.
REQ-039 With SPI_MASTER_LSB_FIRST_EN, lsb_first=1, din=0x01 -> spi_do high on the first bit only.
